// File: rtl/exa_crosb_output_vc_credit_ctrl.sv
// rtl/exa_crosb_output_vc_credit_ctrl.sv - per-(output, VC) downstream credit tracking for the VC crossbar
module exa_crosb_output_vc_credit_ctrl #(
  parameter int output_num = 2,
  parameter int vc_num     = 2,
  parameter int prio_num   = 2,
  parameter int credit_max = 4,
  parameter int cnt_width  = $clog2(credit_max + 1),
  localparam int nvc       = vc_num * prio_num,
  localparam int vc_width  = (nvc > 1) ? $clog2(nvc) : 1
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [output_num-1:0]                        i_tvalid,
  input  logic [output_num-1:0]                        i_tready,
  input  logic [output_num-1:0]                        i_tlast,
  input  logic [output_num-1:0][vc_width-1:0]          i_out_vc,
  input  logic [output_num-1:0][nvc-1:0]               i_credit_return,
  output logic [output_num-1:0][nvc-1:0]               o_output_fifo_credits,
  output logic [output_num-1:0][nvc-1:0][cnt_width-1:0] o_credit_count,
  output logic [output_num-1:0]                        o_err_underflow,
  output logic [output_num-1:0]                        o_err_overflow
);

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  localparam logic [cnt_width-1:0] cnt_full = cnt_width'(credit_max);
  localparam logic [cnt_width-1:0] cnt_one  = cnt_width'(1);

  state_t state_q [output_num];
  state_t state_d [output_num];
  logic [output_num-1:0] acc;
  logic [output_num-1:0] sop;

  logic [output_num-1:0][nvc-1:0][cnt_width-1:0] cnt_q;
  logic [output_num-1:0][nvc-1:0][cnt_width-1:0] cnt_d;
  logic [output_num-1:0] err_uf_q, err_uf_d;
  logic [output_num-1:0] err_of_q, err_of_d;

  // Packet framing: only the first accepted beat of a packet consumes a credit.
  always_ff @(posedge clk) begin
    for (int o = 0; o < output_num; o++) begin
      if (reset) state_q[o] <= IDLE;
      else       state_q[o] <= state_d[o];
    end
  end

  always_comb begin
    acc = i_tvalid & i_tready;
    sop = '0;
    for (int o = 0; o < output_num; o++) begin
      state_d[o] = state_q[o];
      case (state_q[o])
        IDLE: begin
          sop[o] = acc[o];
          if (acc[o] && !i_tlast[o]) state_d[o] = IN_PKT;
        end
        IN_PKT: begin
          if (acc[o] && i_tlast[o]) state_d[o] = IDLE;
        end
        default: state_d[o] = IDLE;
      endcase
    end
  end

  // A simultaneous consume and return cancel out, so the count never dips.
  always_comb begin
    cnt_d    = cnt_q;
    err_uf_d = err_uf_q;
    err_of_d = err_of_q;
    for (int o = 0; o < output_num; o++) begin
      for (int v = 0; v < nvc; v++) begin
        logic dec;
        logic inc;
        dec = sop[o] && (i_out_vc[o] == vc_width'(v));
        inc = i_credit_return[o][v];
        if (dec && !inc) begin
          if (cnt_q[o][v] == '0) err_uf_d[o] = 1'b1;
          else                   cnt_d[o][v] = cnt_q[o][v] - cnt_one;
        end else if (inc && !dec) begin
          if (cnt_q[o][v] == cnt_full) err_of_d[o] = 1'b1;
          else                         cnt_d[o][v] = cnt_q[o][v] + cnt_one;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int o = 0; o < output_num; o++) begin
        for (int v = 0; v < nvc; v++) begin
          cnt_q[o][v] <= cnt_full;
        end
      end
      err_uf_q <= '0;
      err_of_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      err_uf_q <= err_uf_d;
      err_of_q <= err_of_d;
    end
  end

  always_comb begin
    for (int o = 0; o < output_num; o++) begin
      for (int v = 0; v < nvc; v++) begin
        o_output_fifo_credits[o][v] = |cnt_q[o][v];
      end
    end
  end

  assign o_credit_count  = cnt_q;
  assign o_err_underflow = err_uf_q;
  assign o_err_overflow  = err_of_q;

endmodule

// File: tb/tb_exa_crosb_output_vc_credit_ctrl.sv
// tb/tb_exa_crosb_output_vc_credit_ctrl.sv - self-checking bench for the output VC credit controller
module tb_exa_crosb_output_vc_credit_ctrl;

  localparam int ON  = 2;
  localparam int NVC = 4;
  localparam int CW  = 3;
  localparam int VW  = 2;
  localparam int CMAX = 4;

  logic clk = 1'b0;
  logic reset;
  logic [ON-1:0] tvalid, tready, tlast;
  logic [ON-1:0][VW-1:0] out_vc;
  logic [ON-1:0][NVC-1:0] cret;
  logic [ON-1:0][NVC-1:0] credits;
  logic [ON-1:0][NVC-1:0][CW-1:0] cnt;
  logic [ON-1:0] err_uf, err_of;

  int total = 0;
  int bad = 0;

  int m_cred [ON][NVC];
  bit m_inpkt [ON];
  bit m_uf [ON];
  bit m_of [ON];

  always #5 clk = ~clk;

  exa_crosb_output_vc_credit_ctrl #(
    .output_num(2), .vc_num(2), .prio_num(2), .credit_max(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_tvalid(tvalid),
    .i_tready(tready),
    .i_tlast(tlast),
    .i_out_vc(out_vc),
    .i_credit_return(cret),
    .o_output_fifo_credits(credits),
    .o_credit_count(cnt),
    .o_err_underflow(err_uf),
    .o_err_overflow(err_of)
  );

  task clear_inputs();
    tvalid = '0;
    tready = '0;
    tlast  = '0;
    out_vc = '0;
    cret   = '0;
  endtask

  // Reference: credits are a bounded packet count per (output, VC); a packet
  // starts on the first accepted beat after the previous packet's last beat.
  task tick();
    if (reset) begin
      for (int o = 0; o < ON; o++) begin
        for (int v = 0; v < NVC; v++) m_cred[o][v] = CMAX;
        m_inpkt[o] = 0;
        m_uf[o] = 0;
        m_of[o] = 0;
      end
    end else begin
      for (int o = 0; o < ON; o++) begin
        bit accepted;
        bit starts;
        accepted = tvalid[o] && tready[o];
        starts = accepted && !m_inpkt[o];
        if (accepted) m_inpkt[o] = !tlast[o];
        for (int v = 0; v < NVC; v++) begin
          bit take;
          bit give;
          take = starts && (int'(out_vc[o]) == v);
          give = cret[o][v];
          if (take && !give) begin
            if (m_cred[o][v] == 0) m_uf[o] = 1;
            else m_cred[o][v] = m_cred[o][v] - 1;
          end else if (give && !take) begin
            if (m_cred[o][v] == CMAX) m_of[o] = 1;
            else m_cred[o][v] = m_cred[o][v] + 1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    repeat (5) tick();
    for (int o = 0; o < ON; o++) begin
      for (int v = 0; v < NVC; v++) begin
        total++;
        if (cnt[o][v] !== 3'd4) begin
          bad++;
          $display("FAIL reset_cnt o=%0d v=%0d got=%0d exp=4", o, v, cnt[o][v]);
        end
        total++;
        if (credits[o][v] !== 1'b1) begin
          bad++;
          $display("FAIL reset_credit o=%0d v=%0d got=%b exp=1", o, v, credits[o][v]);
        end
      end
    end
    total++;
    if (err_uf !== 2'b00 || err_of !== 2'b00) begin
      bad++;
      $display("FAIL reset_err got uf=%b of=%b exp=00/00", err_uf, err_of);
    end
  endtask

  task test_sop_seq();
    for (int i = 0; i < 4; i++) begin
      tvalid[0] = 1'b1;
      tready[0] = 1'b1;
      tlast[0]  = 1'b1;
      out_vc[0] = 2'd2;
      tick();
      total++;
      if (cnt[0][2] !== 3'(3 - i)) begin
        bad++;
        $display("FAIL sop_seq_cnt step=%0d got=%0d exp=%0d", i, cnt[0][2], 3 - i);
      end
    end
    clear_inputs();
    total++;
    if (credits[0] !== 4'b1011 || credits[1] !== 4'b1111) begin
      bad++;
      $display("FAIL sop_seq_credit got o0=%b o1=%b exp=1011/1111", credits[0], credits[1]);
    end
    for (int o = 0; o < ON; o++) begin
      for (int v = 0; v < NVC; v++) begin
        if (!(o == 0 && v == 2)) begin
          total++;
          if (cnt[o][v] !== 3'd4) begin
            bad++;
            $display("FAIL sop_seq_other o=%0d v=%0d got=%0d exp=4", o, v, cnt[o][v]);
          end
        end
      end
    end
  endtask

  task test_multibeat();
    tvalid[1] = 1'b1;
    tready[1] = 1'b1;
    tlast[1]  = 1'b0;
    out_vc[1] = 2'd1;
    tick();
    out_vc[1] = 2'd3;
    tick();
    tlast[1] = 1'b1;
    tick();
    clear_inputs();
    tick();
    total++;
    if (cnt[1][1] !== 3'd3) begin
      bad++;
      $display("FAIL multibeat_vc1 got=%0d exp=3", cnt[1][1]);
    end
    total++;
    if (cnt[1][3] !== 3'd4) begin
      bad++;
      $display("FAIL multibeat_vc3 got=%0d exp=4", cnt[1][3]);
    end
  endtask

  task test_inc_dec();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tvalid[0] = 1'b1;
    tready[0] = 1'b1;
    tlast[0]  = 1'b1;
    out_vc[0] = 2'd0;
    tick();
    tick();
    out_vc[0] = 2'd1;
    tick();
    clear_inputs();
    total++;
    if (cnt[0][0] !== 3'd2 || cnt[0][1] !== 3'd3) begin
      bad++;
      $display("FAIL incdec_setup got v0=%0d v1=%0d exp=2/3", cnt[0][0], cnt[0][1]);
    end
    tvalid[0] = 1'b1;
    tready[0] = 1'b1;
    tlast[0]  = 1'b1;
    out_vc[0] = 2'd0;
    cret[0][0] = 1'b1;
    tick();
    clear_inputs();
    total++;
    if (cnt[0][0] !== 3'd2 || err_uf !== 2'b00 || err_of !== 2'b00) begin
      bad++;
      $display("FAIL incdec_same got cnt=%0d uf=%b of=%b exp=2/00/00", cnt[0][0], err_uf, err_of);
    end
    cret[0] = 4'b0011;
    tick();
    clear_inputs();
    total++;
    if (cnt[0][0] !== 3'd3 || cnt[0][1] !== 3'd4) begin
      bad++;
      $display("FAIL incdec_multi_ret got v0=%0d v1=%0d exp=3/4", cnt[0][0], cnt[0][1]);
    end
  endtask

  task test_errors();
    for (int i = 0; i < 5; i++) begin
      tvalid[0] = 1'b1;
      tready[0] = 1'b1;
      tlast[0]  = 1'b1;
      out_vc[0] = 2'd2;
      tick();
      if (i == 3) begin
        total++;
        if (err_uf[0] !== 1'b0) begin
          bad++;
          $display("FAIL err_uf_early got=%b exp=0", err_uf[0]);
        end
      end
    end
    clear_inputs();
    total++;
    if (cnt[0][2] !== 3'd0 || err_uf !== 2'b01) begin
      bad++;
      $display("FAIL err_uf got cnt=%0d uf=%b exp=0/01", cnt[0][2], err_uf);
    end
    cret[1][0] = 1'b1;
    tick();
    clear_inputs();
    total++;
    if (cnt[1][0] !== 3'd4 || err_of !== 2'b10) begin
      bad++;
      $display("FAIL err_of got cnt=%0d of=%b exp=4/10", cnt[1][0], err_of);
    end
    repeat (3) tick();
    total++;
    if (err_uf !== 2'b01 || err_of !== 2'b10) begin
      bad++;
      $display("FAIL err_sticky got uf=%b of=%b exp=01/10", err_uf, err_of);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (err_uf !== 2'b00 || err_of !== 2'b00) begin
      bad++;
      $display("FAIL err_clear got uf=%b of=%b exp=00/00", err_uf, err_of);
    end
  endtask

  task test_reset_mid_pkt();
    tvalid[0] = 1'b1;
    tready[0] = 1'b1;
    tlast[0]  = 1'b0;
    out_vc[0] = 2'd3;
    tick();
    total++;
    if (cnt[0][3] !== 3'd3) begin
      bad++;
      $display("FAIL midpkt_first got=%0d exp=3", cnt[0][3]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (cnt[0][3] !== 3'd4) begin
      bad++;
      $display("FAIL midpkt_reset got=%0d exp=4", cnt[0][3]);
    end
    out_vc[0] = 2'd1;
    tick();
    total++;
    if (cnt[0][1] !== 3'd3) begin
      bad++;
      $display("FAIL midpkt_new_sop got=%0d exp=3", cnt[0][1]);
    end
    tlast[0] = 1'b1;
    tick();
    clear_inputs();
    total++;
    if (cnt[0][1] !== 3'd3 || cnt[0][3] !== 3'd4) begin
      bad++;
      $display("FAIL midpkt_tail got v1=%0d v3=%0d exp=3/4", cnt[0][1], cnt[0][3]);
    end
  endtask

  task test_random();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      tvalid = 2'($urandom);
      tready = 2'($urandom);
      tlast  = 2'($urandom);
      out_vc = 4'($urandom);
      for (int o = 0; o < ON; o++) begin
        for (int v = 0; v < NVC; v++) cret[o][v] = ($urandom_range(3) == 0);
      end
      reset = ($urandom_range(99) == 0);
      tick();
      for (int o = 0; o < ON; o++) begin
        for (int v = 0; v < NVC; v++) begin
          total++;
          if (cnt[o][v] !== 3'(m_cred[o][v]) || credits[o][v] !== (m_cred[o][v] != 0)) begin
            bad++;
            $display("FAIL rnd_cnt cyc=%0d o=%0d v=%0d got=%0d/%b exp=%0d", c, o, v,
                     cnt[o][v], credits[o][v], m_cred[o][v]);
          end
        end
        total++;
        if (err_uf[o] !== m_uf[o] || err_of[o] !== m_of[o]) begin
          bad++;
          $display("FAIL rnd_err cyc=%0d o=%0d got uf=%b of=%b exp uf=%b of=%b", c, o,
                   err_uf[o], err_of[o], m_uf[o], m_of[o]);
        end
      end
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_sop_seq();
    test_multibeat();
    test_inc_dec();
    test_errors();
    test_reset_mid_pkt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
